// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer
// Camera register configuration engine. On a one-cycle start pulse it walks
// a synchronous register ROM of {reg_addr, reg_data} entries and issues each
// write to the SCCB master over a valid/ready/done handshake. Delay entries
// stall for DELAY_CYCLES clocks, an END entry (or the last ROM location)
// finishes the sequence, and NACKed writes are re-issued up to MAX_RETRY
// times before the sequence aborts.
//
// Ports:
//   i_sysclk, i_rstn      clock and synchronous active-low reset
//   i_cfg_start           single-cycle start request (ignored while busy)
//   o_rom_addr/i_rom_data ROM read port, data valid one cycle after address
//   o_wr_valid/i_wr_ready write request handshake to the SCCB master
//   o_wr_addr/o_wr_data   register address/data, stable while valid
//   i_wr_done/i_wr_nack   end-of-transaction pulse and its NACK qualifier
//   o_cfg_busy/done/err   sequence status levels
//   o_wr_count            successful writes this sequence, saturating at 255
module cam_cfg_sequencer #(
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic              i_sysclk,
    input  logic              i_rstn,
    input  logic              i_cfg_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [7:0]        o_wr_addr,
    output logic [7:0]        o_wr_data,
    input  logic              i_wr_done,
    input  logic              i_wr_nack,
    output logic              o_cfg_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic [7:0]        o_wr_count
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [15:0] ENT_END   = 16'hFFFF;
    localparam logic [15:0] ENT_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_REQ,
        S_WAIT,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       entry_q, entry_d;
    logic              wr_valid_q, wr_valid_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic              advance;

    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            entry_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            retry_q    <= '0;
            dly_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            entry_q    <= entry_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            retry_q    <= retry_d;
            dly_q      <= dly_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        entry_d    = entry_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        retry_d    = retry_q;
        dly_d      = dly_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_cfg_start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                end
            end
            // ROM registers the address at the end of FETCH; data is
            // captured one cycle later in LATCH.
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                entry_d = i_rom_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (entry_q == ENT_END) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (entry_q == ENT_DELAY) begin
                    dly_d   = DW'(DELAY_CYCLES - 1);
                    state_d = S_DELAY;
                end else begin
                    wr_addr_d  = entry_q[15:8];
                    wr_data_d  = entry_q[7:0];
                    wr_valid_d = 1'b1;
                    retry_d    = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_valid_q && i_wr_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_wr_done) begin
                    if (!i_wr_nack) begin
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                        advance = 1'b1;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d    = retry_q + RW'(1);
                        wr_valid_d = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == '0) advance = 1'b1;
                else             dly_d   = dly_q - DW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Shared exit of a completed write or delay: the last ROM location
        // acts as an implicit END rather than wrapping to address 0.
        if (advance) begin
            if (rom_addr_q == '1) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                rom_addr_d = rom_addr_q + ROM_AW'(1);
                state_d    = S_FETCH;
            end
        end
    end

    assign o_rom_addr = rom_addr_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_cfg_busy = busy_q;
    assign o_cfg_done = done_q;
    assign o_cfg_err  = err_q;
    assign o_wr_count = count_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Testbench for cam_cfg_sequencer: a table of ROM scenarios with expected
// final status, plus directed sequences for busy-start, reset and no-END ROM.
module tb_cam_cfg_sequencer;

    localparam int DLY      = 50;
    localparam int MAXR     = 3;
    localparam int DONE_DLY = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, start2;
    // main DUT (ROM_AW=8)
    logic [7:0]  rom_addr;
    logic [15:0] rom_q;
    logic [15:0] rom_mem [256];
    logic        wr_valid, wr_ready, wr_done, wr_nack;
    logic [7:0]  wr_addr, wr_data, count;
    logic        busy, done, err;
    // second DUT (ROM_AW=2, no END entry)
    logic [1:0]  rom2_addr;
    logic [15:0] rom2_q;
    logic [15:0] rom2_mem [4];
    logic        valid2, done2;
    logic        ready2 = 1'b1;
    logic        nack2  = 1'b0;
    logic [7:0]  addr2, data2, count2;
    logic        busy2, cfgdone2, err2;

    cam_cfg_sequencer #(.ROM_AW(8), .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)) dut (
        .i_sysclk(clk), .i_rstn(rstn), .i_cfg_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_q),
        .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .i_wr_done(wr_done), .i_wr_nack(wr_nack),
        .o_cfg_busy(busy), .o_cfg_done(done), .o_cfg_err(err),
        .o_wr_count(count)
    );

    cam_cfg_sequencer #(.ROM_AW(2), .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)) dut2 (
        .i_sysclk(clk), .i_rstn(rstn), .i_cfg_start(start2),
        .o_rom_addr(rom2_addr), .i_rom_data(rom2_q),
        .o_wr_valid(valid2), .i_wr_ready(ready2),
        .o_wr_addr(addr2), .o_wr_data(data2),
        .i_wr_done(done2), .i_wr_nack(nack2),
        .o_cfg_busy(busy2), .o_cfg_done(cfgdone2), .o_cfg_err(err2),
        .o_wr_count(count2)
    );

    // Synchronous ROMs: data valid one cycle after the address.
    always @(posedge clk) rom_q  <= rom_mem[rom_addr];
    always @(posedge clk) rom2_q <= rom2_mem[rom2_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SCCB master model for the main DUT ----------------
    logic        ready_tied = 1'b1;   // ready level when not stalling
    int          ready_lag  = 0;      // cycles to hold ready low per request
    int          nack_from  = 0;      // response indices [from,to) are NACKed
    int          nack_to    = 0;
    int          resp_n     = 0;      // done responses issued so far
    int          stall_cyc  = 0;
    int          stall_bad  = 0;
    logic [15:0] acc_q [$];           // accepted {addr,data}
    logic        pend, resp_busy, have_stall;
    logic [15:0] pend_ad, stall_ad;
    int          dly, lag_cnt;

    initial begin
        wr_ready = 1'b1; wr_done = 1'b0; wr_nack = 1'b0;
        pend = 1'b0; resp_busy = 1'b0; have_stall = 1'b0;
        pend_ad = '0; stall_ad = '0; dly = 0; lag_cnt = 0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
            if (!rstn) begin
                resp_busy = 1'b0; pend = 1'b0; lag_cnt = 0; have_stall = 1'b0;
                wr_ready = ready_tied;
            end else begin
                if (pend) begin
                    // handshake completed at the previous rising edge
                    acc_q.push_back(pend_ad);
                    resp_busy = 1'b1; dly = DONE_DLY; lag_cnt = 0; have_stall = 1'b0;
                    wr_ready = ready_tied;
                end else if (resp_busy) begin
                    dly--;
                    if (dly == 0) begin
                        resp_busy = 1'b0;
                        wr_done   = 1'b1;
                        wr_nack   = (resp_n >= nack_from && resp_n < nack_to);
                        resp_n++;
                    end
                end else if (!wr_valid) begin
                    wr_ready = ready_tied;
                end else if (!wr_ready) begin
                    if (lag_cnt >= ready_lag) begin
                        wr_ready = 1'b1;
                    end else begin
                        lag_cnt++;
                        stall_cyc++;
                        if (!have_stall) begin
                            have_stall = 1'b1;
                            stall_ad   = {wr_addr, wr_data};
                        end else if ({wr_addr, wr_data} !== stall_ad) begin
                            stall_bad++;
                        end
                    end
                end
                pend    = wr_valid && wr_ready;
                pend_ad = {wr_addr, wr_data};
            end
        end
    end

    // ---------------- minimal SCCB model for the ROM_AW=2 DUT ----------------
    logic [15:0] acc2_q [$];
    logic        pend2, busy2r;
    logic [15:0] pend2_ad;
    int          d2;

    initial begin
        done2 = 1'b0; pend2 = 1'b0; busy2r = 1'b0; pend2_ad = '0; d2 = 0;
        forever begin
            @(negedge clk);
            done2 = 1'b0;
            if (!rstn) begin
                pend2 = 1'b0; busy2r = 1'b0;
            end else begin
                if (pend2) begin
                    acc2_q.push_back(pend2_ad);
                    d2 = 3; busy2r = 1'b1;
                end else if (busy2r) begin
                    d2--;
                    if (d2 == 0) begin
                        done2  = 1'b1;
                        busy2r = 1'b0;
                    end
                end
                pend2    = valid2;
                pend2_ad = {addr2, data2};
            end
        end
    end

    // ---------------- scenario table ----------------
    typedef struct {
        logic [15:0] e0, e1, e2, e3;   // ROM entries 0..3 (rest are END)
        int          lag;              // ready-low cycles per request
        int          nack_after;       // ACKed responses before NACKs start
        int          nacks;            // number of consecutive NACKs
        logic [7:0]  x_count;
        logic [7:0]  x_rom_addr;
        logic        x_done;
        logic        x_err;
        int          x_acc;            // expected number of accepted requests
    } vec_t;

    vec_t vecs [5];

    task automatic load_rom(input logic [15:0] e0, e1, e2, e3);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = e0; rom_mem[1] = e1; rom_mem[2] = e2; rom_mem[3] = e3;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_valid"}, wr_valid, 0);
        chk({tag, "_waddr"}, wr_addr, 0);
        chk({tag, "_wdata"}, wr_data, 0);
        chk({tag, "_raddr"}, rom_addr, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts a sequence and runs it to completion; reports the cycle of the
    // first valid and how many cycles the ROM address sat at 1.
    task automatic run_seq(output int fv, output int a1);
        int cyc;
        pulse_start();
        chk("start_busy",  busy, 1);
        chk("start_count", count, 0);
        chk("start_done",  done, 0);
        chk("start_err",   err, 0);
        chk("start_raddr", rom_addr, 0);
        cyc = 1; fv = -1; a1 = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            if (wr_valid && fv < 0) fv = cyc;
            if (rom_addr == 8'd1) a1++;
            @(negedge clk);
            cyc++;
        end
        chk("seq_finished", busy, 0);
    endtask

    task automatic run_vec(input int v);
        logic [15:0] ents [4];
        logic [15:0] exp_q [$];
        int base, s0, b0, fv, a1, r, tries;
        logic nk, abort;
        vec_t t;
        t = vecs[v];
        ents[0] = t.e0; ents[1] = t.e1; ents[2] = t.e2; ents[3] = t.e3;
        load_rom(t.e0, t.e1, t.e2, t.e3);
        ready_tied = (t.lag == 0);
        ready_lag  = t.lag;
        nack_from  = resp_n + t.nack_after;
        nack_to    = nack_from + t.nacks;
        base = acc_q.size(); s0 = stall_cyc; b0 = stall_bad;

        // expected request stream: each write re-issued per NACK until
        // the retry budget is spent
        r = 0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ents[i] == 16'hFFFF) break;
            if (ents[i] == 16'hFFF0) continue;
            tries = 0;
            forever begin
                exp_q.push_back(ents[i]);
                nk = (r >= t.nack_after && r < t.nack_after + t.nacks);
                r++;
                if (!nk) break;
                if (tries < MAXR) tries++;
                else begin abort = 1'b1; break; end
            end
            if (abort) break;
        end

        run_seq(fv, a1);
        @(negedge clk);
        chk($sformatf("v%0d_first_valid", v), fv, 4);
        chk($sformatf("v%0d_count", v), count, t.x_count);
        chk($sformatf("v%0d_done", v), done, t.x_done);
        chk($sformatf("v%0d_err", v), err, t.x_err);
        chk($sformatf("v%0d_raddr", v), rom_addr, t.x_rom_addr);
        chk($sformatf("v%0d_accepts", v), acc_q.size() - base, t.x_acc);
        chk($sformatf("v%0d_model_len", v), exp_q.size(), t.x_acc);
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < acc_q.size())
                chk($sformatf("v%0d_req%0d", v, k), acc_q[base + k], exp_q[k]);
        chk($sformatf("v%0d_stalls", v), stall_cyc - s0, t.lag);
        chk($sformatf("v%0d_stall_stable", v), stall_bad - b0, 0);
        // delay entry: FETCH+LATCH+DECODE of entry 1 plus DLY cycles
        if (t.e1 == 16'hFFF0) chk("v1_delay_span", a1, 3 + DLY);
    endtask

    task automatic wait_acc(input int n, input string tag);
        int c;
        c = 0;
        while (acc_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk(tag, acc_q.size() >= n, 1);
    endtask

    initial begin
        int base, c, fv, a1;
        rstn = 1'b0; start = 1'b0; start2 = 1'b0;
        load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        rom2_mem[0] = 16'h1101; rom2_mem[1] = 16'h1202;
        rom2_mem[2] = 16'h1303; rom2_mem[3] = 16'h1404;
        //           e0        e1        e2        e3        lag na nk cnt  raddr done err acc
        vecs[0] = '{16'h1280, 16'h1204, 16'h1100, 16'hFFFF, 0, 0, 0, 8'd3, 8'd3, 1'b1, 1'b0, 3};
        vecs[1] = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF, 0, 0, 0, 8'd2, 8'd3, 1'b1, 1'b0, 2};
        vecs[2] = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 7, 0, 0, 8'd1, 8'd1, 1'b1, 1'b0, 1};
        vecs[3] = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 2, 8'd1, 8'd1, 1'b1, 1'b0, 3};
        vecs[4] = '{16'h1280, 16'h1204, 16'h1100, 16'hFFFF, 0, 1, 4, 8'd1, 8'd1, 1'b0, 1'b1, 5};

        repeat (3) @(negedge clk);
        chk_reset("rst");
        chk("rst_busy2", busy2, 0);
        chk("rst_valid2", valid2, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(v);

        // start pulse while busy is ignored (also restarts from ERR)
        load_rom(16'h1280, 16'h1204, 16'h1100, 16'hFFFF);
        ready_tied = 1'b1; ready_lag = 0; nack_from = 0; nack_to = 0;
        base = acc_q.size();
        pulse_start();
        chk("busy_start_err_clear", err, 0);
        wait_acc(base + 1, "busy_first_accept");
        pulse_start();
        c = 0;
        while (busy === 1'b1 && c < 3000) begin @(negedge clk); c++; end
        @(negedge clk);
        chk("busy_ignored_accepts", acc_q.size() - base, 3);
        chk("busy_ignored_count", count, 3);
        chk("busy_ignored_done", done, 1);
        chk("busy_ignored_raddr", rom_addr, 3);

        // reset while waiting for the second write's done
        base = acc_q.size();
        pulse_start();
        wait_acc(base + 2, "wait_second_accept");
        chk("pre_reset_count", count, 1);
        chk("pre_reset_waddr", wr_addr, 8'h12);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset("rst_wait");
        rstn = 1'b1;
        @(negedge clk);

        // reset while a request is stalled on ready
        ready_tied = 1'b0; ready_lag = 20;
        pulse_start();
        c = 0;
        while (wr_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        chk("stalled_valid_seen", wr_valid, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", wr_valid, 0);
        chk("rst_req_busy", busy, 0);
        chk("rst_req_raddr", rom_addr, 0);
        ready_tied = 1'b1; ready_lag = 0;
        rstn = 1'b1;
        @(negedge clk);

        // ROM_AW=2 with no END: four writes then DONE at the last address
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("noend_busy", busy2, 1);
        c = 0;
        while (busy2 === 1'b1 && c < 500) begin @(negedge clk); c++; end
        @(negedge clk);
        chk("noend_done", cfgdone2, 1);
        chk("noend_err", err2, 0);
        chk("noend_count", count2, 4);
        chk("noend_raddr", rom2_addr, 3);
        chk("noend_accepts", acc2_q.size(), 4);
        if (acc2_q.size() == 4) begin
            chk("noend_req0", acc2_q[0], 16'h1101);
            chk("noend_req3", acc2_q[3], 16'h1404);
        end
        chk("noend_main_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
